// File: rtl/fll_cfg_apb_bridge.sv
// APB slave bridging register accesses onto the FLL CFGREQ/CFGACK port.
// Optional macro FLL_CFG_TIMEOUT_EN adds an ack timeout that aborts with PSLVERR.
module fll_cfg_apb_bridge #(
  parameter int CFG_ADDR_WIDTH = 4,
  parameter int CFG_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [CFG_DATA_WIDTH-1:0] pwdata_i,
  output logic [CFG_DATA_WIDTH-1:0] prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      cfg_req_o,
  input  logic                      cfg_ack_i,
  output logic [CFG_ADDR_WIDTH-1:0] cfg_addr_o,
  output logic [CFG_DATA_WIDTH-1:0] cfg_wdata_o,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_rdata_i,
  output logic                      cfg_web_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      req_q, req_d;
  logic                      web_q, web_d;
  logic                      err_q, err_d;
  logic [CFG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CFG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CFG_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      addr_ok;
  logic                      setup;
  logic                      to_hit;
  logic                      cnt_clr;
  logic                      cnt_inc;

  // Word-aligned and inside the 2^CFG_ADDR_WIDTH register window.
  generate
    if (APB_ADDR_WIDTH > CFG_ADDR_WIDTH + 2) begin : g_hi
      assign addr_ok =
        (paddr_i[1:0] == 2'b00) &&
        (paddr_i[APB_ADDR_WIDTH-1:CFG_ADDR_WIDTH+2] == '0);
    end else begin : g_nohi
      assign addr_ok = (paddr_i[1:0] == 2'b00);
    end
  endgenerate

  // A new access is accepted only in the APB setup phase.
  assign setup = psel_i && !penable_i;

`ifdef FLL_CFG_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Fires in the REQ cycle that would bring the count to the limit.
  assign to_hit =
    ({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES);

  // Counts REQ cycles spent waiting for the FLL ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and datapath decisions for one config access.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    web_d   = web_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (addr_ok) begin
            addr_d  = paddr_i[CFG_ADDR_WIDTH+1:2];
            wdata_d = pwdata_i;
            web_d   = ~pwrite_i;
            req_d   = 1'b1;
            err_d   = 1'b0;
            cnt_clr = 1'b1;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (cfg_ack_i) begin
          req_d   = 1'b0;
          rdata_d = web_q ? cfg_rdata_i : '0;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (to_hit) begin
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered FLL/APB outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      web_q   <= 1'b1;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      web_q   <= web_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign pready_o    = (state_q == DONE);
  assign pslverr_o   = pready_o && err_q;
  assign busy_o      = (state_q != IDLE);
  assign cfg_req_o   = req_q;
  assign cfg_web_o   = web_q;
  assign cfg_addr_o  = addr_q;
  assign cfg_wdata_o = wdata_q;
  assign prdata_o    = rdata_q;

endmodule

// File: tb/tb_fll_cfg_apb_bridge.sv
// Randomized bench for fll_cfg_apb_bridge against a transaction-timeline model.
// Timeout checks follow FLL_CFG_TIMEOUT_EN when it is defined.
module tb_fll_cfg_apb_bridge;

  localparam int AW = 12;
  localparam int CW = 4;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef FLL_CFG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;
  logic          cfg_req, cfg_ack, cfg_web, busy;
  logic [CW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata, cfg_rdata;

  fll_cfg_apb_bridge #(
    .CFG_ADDR_WIDTH(CW),
    .CFG_DATA_WIDTH(DW),
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .psel_i(psel),
    .penable_i(penable),
    .pwrite_i(pwrite),
    .paddr_i(paddr),
    .pwdata_i(pwdata),
    .prdata_o(prdata),
    .pready_o(pready),
    .pslverr_o(pslverr),
    .cfg_req_o(cfg_req),
    .cfg_ack_i(cfg_ack),
    .cfg_addr_o(cfg_addr),
    .cfg_wdata_o(cfg_wdata),
    .cfg_rdata_i(cfg_rdata),
    .cfg_web_o(cfg_web),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic          e_req, e_ready, e_err, e_busy, e_web;
  logic [CW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_prdata;
  bit            chk_en = 1'b0;
  int            rdy_cyc = -1;
  logic          rdy_err = 1'b0;

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_req", 32'(cfg_req), 32'(e_req));
      chk("pready", 32'(pready), 32'(e_ready));
      chk("pslverr", 32'(pslverr), 32'(e_ready & e_err));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("cfg_web", 32'(cfg_web), 32'(e_web));
      chk("cfg_addr", 32'(cfg_addr), 32'(e_addr));
      chk("cfg_wdata", cfg_wdata, e_wdata);
      chk("prdata", prdata, e_prdata);
      if (pready) begin
        rdy_cyc <= cyc;
        rdy_err <= pslverr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_reset();
    e_req    = 1'b0;
    e_ready  = 1'b0;
    e_err    = 1'b0;
    e_busy   = 1'b0;
    e_web    = 1'b1;
    e_addr   = '0;
    e_wdata  = '0;
    e_prdata = '0;
  endtask

  task automatic set_idle();
    psel      = 1'b0;
    penable   = 1'b0;
    cfg_ack   = 1'($urandom);
    cfg_rdata = $urandom;
    e_req     = 1'b0;
    e_ready   = 1'b0;
    e_err     = 1'b0;
    e_busy    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      set_idle();
    end
  endtask

  // One APB transfer; the model derives the whole timeline from the
  // ack delay d: ack rises d cycles after the request appears, unless
  // the timeout (when built in) expires first.
  task automatic xfer(input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int d,
                      input bit tied, input bit rfix,
                      input logic [DW-1:0] rfv, output int lat);
    int t0;
    bit legal;
    bit timed;
    int n;
    int exp_lat;
    logic [DW-1:0] cap;
    t0    = cyc;
    legal = (a[1:0] == 2'b00) && (a[AW-1:CW+2] == '0);
    cap   = '0;
    psel      = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
    cfg_ack   = tied;
    cfg_rdata = $urandom;
    step();
    penable = 1'b1;
    if (!legal) begin
      e_ready = 1'b1;
      e_err   = 1'b1;
      e_busy  = 1'b1;
      cfg_ack = 1'($urandom);
      step();
      exp_lat = 1;
    end else begin
      timed = TO_EN && !tied && (d >= TO);
      n     = timed ? TO : (tied ? 1 : d + 1);
      e_addr  = a[CW+1:2];
      e_wdata = wd;
      e_web   = !wr;
      e_req   = 1'b1;
      e_busy  = 1'b1;
      for (int k = 1; k <= n; k++) begin
        cfg_ack   = tied || (k - 1 >= d);
        cfg_rdata = rfix ? rfv : $urandom;
        if (k == n && !timed) cap = cfg_rdata;
        step();
      end
      e_req    = 1'b0;
      e_ready  = 1'b1;
      e_err    = timed;
      e_prdata = (timed || wr) ? '0 : cap;
      cfg_ack   = 1'($urandom);
      cfg_rdata = $urandom;
      step();
      exp_lat = n + 1;
    end
    lat = rdy_cyc - t0;
    chk("latency", 32'(lat), 32'(exp_lat));
    set_idle();
  endtask

  int lat;

  initial begin
    rst_n     = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    cfg_ack   = 1'b0;
    cfg_rdata = '0;
    exp_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    set_idle();
    idle(1);

    // Write with ack tied high.
    xfer(1'b1, 12'h008, 32'h0000_00A5, 0, 1'b1, 1'b0, '0, lat);
    chk("lit_wr_lat", 32'(lat), 32'd2);
    chk("lit_wr_addr", 32'(cfg_addr), 32'd2);
    chk("lit_wr_web", 32'(cfg_web), 32'd0);
    chk("lit_wr_wdata", cfg_wdata, 32'h0000_00A5);
    chk("lit_wr_err", 32'(rdy_err), 32'd0);
    idle(1);

    // Read with three extra ack cycles.
    xfer(1'b0, 12'h004, 32'h1234_5678, 3, 1'b0, 1'b1,
         32'hDEAD_BEEF, lat);
    chk("lit_rd_lat", 32'(lat), 32'd5);
    chk("lit_rd_data", prdata, 32'hDEAD_BEEF);
    chk("lit_rd_addr", 32'(cfg_addr), 32'd1);
    chk("lit_rd_web", 32'(cfg_web), 32'd1);

    // Misaligned and out-of-window addresses.
    xfer(1'b1, 12'h002, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, '0, lat);
    chk("lit_ill1_lat", 32'(lat), 32'd1);
    chk("lit_ill1_err", 32'(rdy_err), 32'd1);
    xfer(1'b0, 12'h040, 32'h0, 0, 1'b1, 1'b0, '0, lat);
    chk("lit_ill2_lat", 32'(lat), 32'd1);
    chk("lit_ill2_err", 32'(rdy_err), 32'd1);
    chk("lit_ill2_data", prdata, 32'hDEAD_BEEF);
    idle(2);

    // Ack arriving late, and never.
    xfer(1'b0, 12'h03C, 32'h0, TO - 1, 1'b0, 1'b1,
         32'hCAFE_F00D, lat);
    chk("lit_late_lat", 32'(lat), 32'(TO + 1));
    chk("lit_late_err", 32'(rdy_err), 32'd0);
    chk("lit_late_data", prdata, 32'hCAFE_F00D);
    xfer(1'b0, 12'h010, 32'h0, 20, 1'b0, 1'b1,
         32'h5555_AAAA, lat);
    if (TO_EN) begin
      chk("lit_to_lat", 32'(lat), 32'(TO + 1));
      chk("lit_to_err", 32'(rdy_err), 32'd1);
      chk("lit_to_data", prdata, 32'h0);
    end else begin
      chk("lit_noto_lat", 32'(lat), 32'd22);
      chk("lit_noto_err", 32'(rdy_err), 32'd0);
      chk("lit_noto_data", prdata, 32'h5555_AAAA);
    end
    idle(1);

    // Asynchronous reset while a request is outstanding.
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 12'h00C;
    pwdata  = 32'h0BAD_0BAD;
    cfg_ack = 1'b0;
    step();
    penable = 1'b1;
    e_addr  = 4'd3;
    e_web   = 1'b1;
    e_wdata = 32'h0BAD_0BAD;
    e_req   = 1'b1;
    e_busy  = 1'b1;
    #2;
    chk("pre_rst_req", 32'(cfg_req), 32'd1);
    rst_n = 1'b0;
    exp_reset();
    psel    = 1'b0;
    penable = 1'b0;
    #1;
    chk("rst_req_async", 32'(cfg_req), 32'd0);
    chk("rst_busy_async", 32'(busy), 32'd0);
    chk("rst_web_async", 32'(cfg_web), 32'd1);
    step();
    step();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    set_idle();
    xfer(1'b1, 12'h014, 32'h7777_0001, 2, 1'b0, 1'b0, '0, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      if ($urandom % 4 != 0)
        a = {6'b0, 4'($urandom), 2'b00};
      else
        a = AW'($urandom);
      xfer(1'($urandom), a, $urandom, $urandom_range(0, 12),
           ($urandom % 8 == 0), 1'b0, '0, lat);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
